// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned InstrWidth = 32;

  // EBREAK stops fetching once it has been captured.
  localparam logic [InstrWidth-1:0] EbreakInstr = 32'h0010_0073;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, redirect request, output
// handshake and status. master = fetch_ctrl side, slave = environment side.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  import fetch_ctrl_pkg::*;

  logic                  en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [InstrWidth-1:0] imem_instr;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [InstrWidth-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  misalign_err;
  logic                  halted;
  logic [31:0]           fetch_count;

  modport master (
    input  en, imem_instr, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, misalign_err, halted, fetch_count
  );

  modport slave (
    output en, imem_instr, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, misalign_err, halted, fetch_count
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output holding register for fetched instructions.
// flush wins over load; load wins over a plain acceptance.
module fetch_out_reg
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  accept,
  input  logic [InstrWidth-1:0] in_instr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  output logic [InstrWidth-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  logic                  valid_q;
  logic [InstrWidth-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  // Capture a new instruction, drop it on flush, or empty it once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: pc register, IDLE/RUN/HALT FSM, redirect
// handling and a one-entry registered output stage.
// Optional feature: define FETCH_CTRL_PERF_EN to build the saturating
// accepted-instruction counter; otherwise fetch_count is tied to zero.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(4);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic                  fetch;
  logic                  accept;
  logic                  out_valid;

  assign accept = out_valid && bus.out_ready;

  // Next state, next pc and fetch strobe; a redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    fetch      = 1'b0;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      if (bus.redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
      if (state_q == StHalt) state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle: if (bus.en) state_d = StRun;
        StRun: begin
          if (!out_valid || bus.out_ready) begin
            fetch = 1'b1;
            pc_d  = pc_q + PcStep;
            if (bus.imem_instr == EbreakInstr) state_d = StHalt;
          end
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State, pc and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_out_reg #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .load     (fetch),
    .accept   (accept),
    .in_instr (bus.imem_instr),
    .in_pc    (pc_q),
    .out_valid(out_valid),
    .out_instr(bus.out_instr),
    .out_pc   (bus.out_pc)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] count_q;

  // Count accepted transfers, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = 32'd0;
`endif

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.misalign_err = misalign_q;
  assign bus.halted       = (state_q == StHalt);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width of the instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  start fetching from IDLE.
REQ-006 SHALL have port imem_addr  output  ADDR_WIDTH  byte address to instr_mem; combinational read, data same cycle.
REQ-007 SHALL have port imem_instr  input  32  instruction word returned by instr_mem.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-010 SHALL have port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts when out_valid and out_ready both high.
REQ-012 SHALL have port out_instr  output  32  registered instruction.
REQ-013 SHALL have port out_pc  output  ADDR_WIDTH  address of out_instr.
REQ-014 SHALL have port misalign_err  output  1  sticky flag: a redirect had redirect_pc[1:0] != 0.
REQ-015 SHALL have port halted  output  1  high in state HALT.
REQ-016 SHALL have port fetch_count  output  32  accepted-instruction count (see Configuration).

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; imem_addr SHALL equal internal pc register at all times.
REQ-018 IDLE -> RUN on rising edge with en=1; no fetch issued in IDLE.
REQ-019 In RUN, a fetch SHALL occur in a cycle when (!out_valid || out_ready) && !redirect_valid: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4; latency one cycle from address to out_valid.
REQ-020 pc increment SHALL wrap modulo 2^ADDR_WIDTH (max word address + 4 -> 0).
REQ-021 While out_valid && !out_ready, out_instr, out_pc, out_valid and pc SHALL stay stable.
REQ-022 out_ready with out_valid=0 SHALL be ignored.
REQ-023 redirect_valid SHALL have priority over fetch in every state: pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}, out_valid<=0 (pending instruction discarded); first post-redirect instruction valid two edges after redirect.
REQ-024 Redirect and acceptance in the same cycle: acceptance counts as consumed, then redirect applies.
REQ-025 Redirect in IDLE SHALL update pc and stay IDLE; redirect in HALT SHALL update pc and go RUN.
REQ-026 Capturing 32'h00100073 (EBREAK) SHALL present it normally and move RUN -> HALT; HALT issues no fetch, pc holds at EBREAK address + 4.
REQ-027 misalign_err SHALL set on any redirect with redirect_pc[1:0] != 0 and clear only on reset.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, halted=0, fetch_count=0.
REQ-029 Reset mid-transfer SHALL discard any pending output; no acceptance counted.

Configuration
REQ-030 Macro FETCH_CTRL_PERF_EN defined: fetch_count increments by 1 per accepted transfer, saturating at 32'hFFFFFFFF.
REQ-031 Macro undefined: fetch_count SHALL be constant 0 and no counter register synthesised.

Structure
REQ-032 Shared package SHALL hold state encoding typedef (IDLE/RUN/HALT), EBREAK opcode constant, instruction width 32.
REQ-033 One sub-module natural: fetch_out_reg (valid/ready output holding register); pc/FSM stay in fetch_ctrl.

Verification (instr_mem preloaded 0x000:00000013, 0x004:00100093, 0x008:00200113, 0x00C:00308193)
REQ-034 Reset release, en=1, out_ready=1 -> consecutive (pc,instr) = (0x000,00000013),(0x004,00100093),(0x008,00200113),(0x00C,00308193), one per cycle.
REQ-035 out_ready=0 for 3 cycles at out_pc=0x004 -> out_instr held 00100093, imem_addr held 0x008; resume -> 0x008 next.
REQ-036 redirect_valid with redirect_pc=0x00E while out_pc=0x004 pending -> 0x004 dropped, misalign_err=1, next out_pc=0x00C, instr 00308193.
REQ-037 Word 00100073 at 0x010 -> presented at out_pc 0x010, halted=1, no further out_valid; redirect 0x000 -> RUN, 00000013 next.
REQ-038 pc at 0xFFC (ADDR_WIDTH=12) -> next out_pc=0x000; rst_n low while out_valid=1 -> out_valid=0 at once, fetch_count=0 (PERF_EN build), restart at RESET_PC.
